// File: rtl/cache_ctrl_pkg.sv
// Shared types for the direct-mapped, write-through read cache controller.
package cache_ctrl_pkg;

   localparam int BURST_LEN_W = 16;

   typedef logic [BURST_LEN_W-1:0] burst_len_t;

   typedef enum logic [2:0] {
      IDLE,
      RD_RESP,
      FILL_REQ,
      FILL_DATA,
      FILL_WAIT,
      WR_REQ,
      WR_DATA,
      WR_WAIT
   } state_t;

endpackage

// File: rtl/cache_ctrl_line_ram.sv
// Line storage: data words with a registered read port, plus tag/valid arrays
// whose lookup is combinational so hit/miss is known in the accept cycle.
module cache_ctrl_line_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_LINES  = 16,
   parameter int LINE_WORDS = 4,
   parameter int TAG_W      = 26,
   parameter int IDX_W      = $clog2(NUM_LINES),
   parameter int WA_W       = $clog2(NUM_LINES) + $clog2(LINE_WORDS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inv_all_i,
   input  logic [IDX_W-1:0]      lk_idx_i,
   output logic [TAG_W-1:0]      lk_tag_o,
   output logic                  lk_valid_o,
   input  logic                  tag_we_i,
   input  logic [IDX_W-1:0]      tag_widx_i,
   input  logic [TAG_W-1:0]      tag_wdata_i,
   input  logic                  data_we_i,
   input  logic [WA_W-1:0]       data_waddr_i,
   input  logic [DATA_WIDTH-1:0] data_wdata_i,
   input  logic [WA_W-1:0]       data_raddr_i,
   output logic [DATA_WIDTH-1:0] data_rdata_o
);

   logic [NUM_LINES-1:0]  valid_q;
   logic [TAG_W-1:0]      tag_mem [NUM_LINES];
   logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*LINE_WORDS];

   always_ff @(posedge clk) begin
      if (rst || inv_all_i) begin
         valid_q <= '0;
      end else if (tag_we_i) begin
         valid_q[tag_widx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we_i) begin
         tag_mem[tag_widx_i] <= tag_wdata_i;
      end
   end

   // Write-first bypass lets a fill's final beat be returned on the next cycle.
   always_ff @(posedge clk) begin
      if (data_we_i) begin
         data_mem[data_waddr_i] <= data_wdata_i;
      end
      if (data_we_i && (data_waddr_i == data_raddr_i)) begin
         data_rdata_o <= data_wdata_i;
      end else begin
         data_rdata_o <= data_mem[data_raddr_i];
      end
   end

   assign lk_tag_o   = tag_mem[lk_idx_i];
   assign lk_valid_o = valid_q[lk_idx_i];

endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped read cache with write-through/no-write-allocate writes,
// line fills via a burst read port and single-beat memory writes.
//
// state     | meaning
// IDLE      | accept invalidate > write > read
// RD_RESP   | return the requested word for one cycle
// FILL_REQ  | line burst request held until rd_gnt
// FILL_DATA | collect LINE_WORDS beats into the line
// FILL_WAIT | wait for rd_done, then validate the line
// WR_REQ    | single-word write request held until wr_gnt
// WR_DATA   | write beat held until wr_ready
// WR_WAIT   | wait for wr_done
module cache_ctrl_dm
   import cache_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_LINES  = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  acc_rd_valid,
   output logic                  acc_rd_ready,
   input  logic [ADDR_WIDTH-1:0] acc_rd_addr,
   output logic [DATA_WIDTH-1:0] acc_rd_data,
   output logic                  acc_rd_data_valid,
   input  logic                  acc_wr_valid,
   output logic                  acc_wr_ready,
   input  logic [ADDR_WIDTH-1:0] acc_wr_addr,
   input  logic [DATA_WIDTH-1:0] acc_wr_data,
   input  logic                  inv_valid,
   output logic                  inv_ready,
   output logic                  rd_req,
   input  logic                  rd_gnt,
   output logic [15:0]           rd_len,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic                  rd_done,
   output logic                  wr_req,
   input  logic                  wr_gnt,
   output logic [15:0]           wr_len,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic                  wr_last,
   input  logic                  wr_done,
   output logic [31:0]           hit_cnt,
   output logic [31:0]           miss_cnt
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
   localparam int WA_W  = OFF_W + IDX_W;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [OFF_W-1:0]      beat_q, beat_d;
   logic [31:0]           hit_q, hit_d, miss_q, miss_d;

   logic                  is_idle, wr_acc, rd_acc, last_beat, inv_all;
   logic [IDX_W-1:0]      lk_idx;
   logic [TAG_W-1:0]      lk_req_tag, lk_tag;
   logic                  lk_valid, lk_hit;
   logic                  tag_we, data_we;
   logic [WA_W-1:0]       data_waddr, data_raddr;
   logic [DATA_WIDTH-1:0] data_wdata, data_rdata;

   assign is_idle      = (state_q == IDLE);
   assign inv_ready    = is_idle && inv_valid;
   assign acc_wr_ready = is_idle && !inv_valid;
   assign acc_rd_ready = is_idle && !inv_valid && !acc_wr_valid;
   assign inv_all      = inv_ready;
   assign wr_acc       = acc_wr_valid && acc_wr_ready;
   assign rd_acc       = acc_rd_valid && acc_rd_ready;

   assign lk_idx     = acc_wr_valid ? acc_wr_addr[OFF_W +: IDX_W] : acc_rd_addr[OFF_W +: IDX_W];
   assign lk_req_tag = acc_wr_valid ? acc_wr_addr[ADDR_WIDTH-1 -: TAG_W]
                                    : acc_rd_addr[ADDR_WIDTH-1 -: TAG_W];
   assign lk_hit     = lk_valid && (lk_tag == lk_req_tag);

   assign last_beat  = (state_q == FILL_DATA) && rd_valid && (beat_q == LAST_BEAT);
   assign tag_we     = (last_beat || (state_q == FILL_WAIT)) && rd_done;
   assign data_we    = (wr_acc && lk_hit) || ((state_q == FILL_DATA) && rd_valid);
   assign data_waddr = wr_acc ? acc_wr_addr[WA_W-1:0] : {addr_q[WA_W-1:OFF_W], beat_q};
   assign data_wdata = wr_acc ? acc_wr_data : rd_data;
   assign data_raddr = is_idle ? acc_rd_addr[WA_W-1:0] : addr_q[WA_W-1:0];

   cache_ctrl_line_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_LINES  (NUM_LINES),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W)
   ) u_line_ram (
      .clk          (clk),
      .rst          (rst),
      .inv_all_i    (inv_all),
      .lk_idx_i     (lk_idx),
      .lk_tag_o     (lk_tag),
      .lk_valid_o   (lk_valid),
      .tag_we_i     (tag_we),
      .tag_widx_i   (addr_q[OFF_W +: IDX_W]),
      .tag_wdata_i  (addr_q[ADDR_WIDTH-1 -: TAG_W]),
      .data_we_i    (data_we),
      .data_waddr_i (data_waddr),
      .data_wdata_i (data_wdata),
      .data_raddr_i (data_raddr),
      .data_rdata_o (data_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         beat_q  <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         beat_q  <= beat_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      addr_d            = addr_q;
      wdata_d           = wdata_q;
      beat_d            = beat_q;
      hit_d             = hit_q;
      miss_d            = miss_q;
      acc_rd_data_valid = 1'b0;
      acc_rd_data       = '0;
      rd_req            = 1'b0;
      rd_len            = '0;
      rd_addr           = '0;
      rd_ready          = 1'b0;
      wr_req            = 1'b0;
      wr_len            = '0;
      wr_addr           = '0;
      wr_data           = '0;
      wr_valid          = 1'b0;
      wr_last           = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wr_acc) begin
               addr_d  = acc_wr_addr;
               wdata_d = acc_wr_data;
               state_d = WR_REQ;
            end else if (rd_acc) begin
               addr_d = acc_rd_addr;
               if (lk_hit) begin
                  if (hit_q != '1) hit_d = hit_q + 32'd1;
                  state_d = RD_RESP;
               end else begin
                  if (miss_q != '1) miss_d = miss_q + 32'd1;
                  beat_d  = '0;
                  state_d = FILL_REQ;
               end
            end
         end
         RD_RESP: begin
            acc_rd_data_valid = 1'b1;
            acc_rd_data       = data_rdata;
            state_d           = IDLE;
         end
         FILL_REQ: begin
            rd_req  = 1'b1;
            rd_len  = burst_len_t'(LINE_WORDS);
            rd_addr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            if (rd_gnt) state_d = FILL_DATA;
         end
         FILL_DATA: begin
            rd_ready = 1'b1;
            if (rd_valid) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) state_d = rd_done ? RD_RESP : FILL_WAIT;
            end
         end
         FILL_WAIT: begin
            if (rd_done) state_d = RD_RESP;
         end
         WR_REQ: begin
            wr_req  = 1'b1;
            wr_len  = burst_len_t'(1);
            wr_addr = addr_q;
            if (wr_gnt) state_d = WR_DATA;
         end
         WR_DATA: begin
            wr_valid = 1'b1;
            wr_last  = 1'b1;
            wr_data  = wdata_q;
            if (wr_ready) state_d = WR_WAIT;
         end
         WR_WAIT: begin
            if (wr_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign hit_cnt  = hit_q;
   assign miss_cnt = miss_q;

endmodule

// File: doc/cache_ctrl_dm.md
CACHE_CTRL_DM -- requirements
Module: cache_ctrl_dm

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter NUM_LINES, default 16, power of two >= 2, direct-mapped line count.
REQ-004 SHALL have parameter LINE_WORDS, default 4, power of two >= 2, words per line.
REQ-005 SHALL have ports:
 clk  in  1  sole clock, rising edge.
 rst  in  1  synchronous, active-high reset.
 acc_rd_valid / acc_rd_ready  in / out  1  accelerator read handshake.
 acc_rd_addr  in  ADDR_WIDTH  read word address.
 acc_rd_data  out  DATA_WIDTH  read data.
 acc_rd_data_valid  out  1  one-cycle read-data strobe.
 acc_wr_valid / acc_wr_ready  in / out  1  accelerator write handshake.
 acc_wr_addr, acc_wr_data  in  ADDR_WIDTH, DATA_WIDTH  write word address and data.
 inv_valid / inv_ready  in / out  1  invalidate-all request and one-cycle ack.
 rd_req / rd_gnt  out / in  1  memory read-burst request and grant.
 rd_len  out  16  burst beats.
 rd_addr  out  ADDR_WIDTH  burst start address.
 rd_data  in  DATA_WIDTH  burst data.
 rd_valid / rd_ready  in / out  1  read-beat handshake.
 rd_done  in  1  read-burst complete.
 wr_req / wr_gnt  out / in  1  memory write request and grant.
 wr_len  out  16  write beats.
 wr_addr, wr_data  out  ADDR_WIDTH, DATA_WIDTH  write address and data.
 wr_valid / wr_ready  out / in  1  write-beat handshake.
 wr_last  out  1  final beat.
 wr_done  in  1  write complete.
 hit_cnt, miss_cnt  out  32  read hit and miss counters.

Function
REQ-006 Address split: offset = addr[log2(LINE_WORDS)-1:0]; index = next log2(NUM_LINES) bits; tag = remaining bits.
REQ-007 FSM states: IDLE, RD_RESP, FILL_REQ, FILL_DATA, FILL_WAIT, WR_REQ, WR_DATA, WR_WAIT.
REQ-008 inv_ready = (state==IDLE) && inv_valid; acc_wr_ready = (state==IDLE) && !inv_valid; acc_rd_ready = (state==IDLE) && !inv_valid && !acc_wr_valid. Priority is invalidate > write > read.
REQ-009 Invalidate SHALL clear all line valid bits in the handshake cycle and SHALL leave the data array unchanged.
REQ-010 Read hit (line valid and tag match) SHALL go to RD_RESP and drive acc_rd_data_valid=1 with the word exactly 1 cycle after acceptance; hit_cnt increments.
REQ-011 Read miss SHALL increment miss_cnt and go to FILL_REQ: rd_req=1, rd_addr=line-aligned address, rd_len=LINE_WORDS, all held stable until rd_gnt is sampled high.
REQ-012 In FILL_DATA, rd_ready=1; each rd_valid&&rd_ready beat writes the next word (offset 0 upward). After LINE_WORDS beats, rd_ready=0 and the FSM goes to FILL_WAIT.
REQ-013 FILL_WAIT SHALL wait for rd_done, set the line valid with the new tag, and go to RD_RESP, which returns the requested word. Miss latency is therefore rd_done + 1 cycle. rd_done arriving in the same cycle as the last beat SHALL be honoured.
REQ-014 Write (write-through, no-write-allocate): on a hit, update the cached word in the handshake cycle; on a miss, leave the cache untouched. In both cases go to WR_REQ.
REQ-015 WR_REQ: wr_req=1, wr_len=1, and wr_addr held until wr_gnt. WR_DATA: wr_valid=1, wr_last=1, wr_data held until wr_ready. WR_WAIT: wait for wr_done, then return to IDLE.
REQ-016 rd_valid outside FILL_DATA, and done/gnt pulses outside their wait states, SHALL be ignored.
REQ-017 Counters SHALL saturate at 32'hFFFF_FFFF; invalidate does not clear them.
REQ-018 acc_rd_data_valid SHALL be high only in RD_RESP. All memory-side request and valid outputs SHALL be 0 in IDLE.

Reset
REQ-019 On rst: state=IDLE, all valid bits=0, hit_cnt=miss_cnt=0, and every output=0 except acc_rd_ready and acc_wr_ready, which follow REQ-008 after reset deasserts.
REQ-020 Reset mid-burst SHALL abandon the transaction immediately; the memory side tolerates it. Data array contents are undefined after reset.

Structure
REQ-021 Package cache_ctrl_pkg SHALL hold the state enum and a burst-length type (16 bits).
REQ-022 Sub-module cache_ctrl_line_ram SHALL hold data and tag+valid arrays: one write port, one registered read port.

Verification (NUM_LINES=16, LINE_WORDS=4)
REQ-023 Read 0x40 after reset -> miss_cnt=1; rd_addr=0x40, rd_len=4; beats A0..A3 returned; acc_rd_data=A0 one cycle after rd_done.
REQ-024 Then read 0x43 -> hit, acc_rd_data=A3 exactly 1 cycle later, hit_cnt=1, no rd_req.
REQ-025 Write 0x41=0xDEAD -> wr_addr=0x41, wr_len=1, wr_last=1; a following read of 0x41 hits and returns 0xDEAD.
REQ-026 Read 0x140 (same index, different tag) -> miss and refill; a later read of 0x40 misses again.
REQ-027 inv_valid and acc_wr_valid asserted together in IDLE -> invalidate first, acc_wr_ready=0 that cycle; a later read of 0x140 misses.
REQ-028 rst asserted during FILL_DATA after 2 beats -> next cycle rd_ready=0, state IDLE; re-read of 0x40 misses.
